// File: rtl/display_arbiter_pkg.sv
// Shared encodings and widths for the 4-digit display arbiter.
// The FSM state encoding is identical to the active_src encoding, so the state drives it directly.
package display_pkg;

    localparam int DIGITS_W = 16;
    localparam int DIGIT_W  = 4;

    localparam logic [1:0] SRC_BG   = 2'd0;
    localparam logic [1:0] SRC_MSG1 = 2'd1;
    localparam logic [1:0] SRC_MSG2 = 2'd2;

    typedef enum logic [1:0] {
        ST_BG   = SRC_BG,
        ST_MSG1 = SRC_MSG1,
        ST_MSG2 = SRC_MSG2
    } state_e;

endpackage

// File: rtl/display_arbiter_blink_gen.sv
// Blink phase generator: toggles every BLINK_HALF enabled cycles, restart forces count 0 / phase on.
// The phase output is the next-state value, so a restart is visible on the restart edge itself.
module blink_gen #(
    parameter int BLINK_HALF = 125
) (
    input  logic clk_500Hz,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic phase
);

    localparam int CNT_W = $clog2(BLINK_HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             phase_q;
    logic             phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (enable) begin
            // Terminal count reloads to zero rather than wrapping through the full range.
            if (cnt_q >= CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_d;

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates the 4-digit display between background digits and two prioritised transient messages.
// All outputs are registered one stage after the FSM state, so content and active_src switch together.
module display_arbiter
    import display_pkg::*;
#(
    parameter int HOLD_TICKS = 1000,
    parameter int BLINK_HALF = 125
) (
    input  logic                clk_500Hz,
    input  logic                rst_n,
    input  logic [DIGITS_W-1:0] bg_digits,
    input  logic                bg_blink,
    input  logic                msg1_req,
    input  logic [DIGITS_W-1:0] msg1_digits,
    output logic                msg1_ack,
    input  logic                msg2_req,
    input  logic [DIGITS_W-1:0] msg2_digits,
    output logic                msg2_ack,
    input  logic                cancel,
    output logic                disp_en,
    output logic [DIGIT_W-1:0]  content_0,
    output logic [DIGIT_W-1:0]  content_1,
    output logic [DIGIT_W-1:0]  content_2,
    output logic [DIGIT_W-1:0]  content_3,
    output logic [1:0]          active_src,
    output logic                busy
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DIGITS_W-1:0] msg1_q, msg1_d;
    logic [DIGITS_W-1:0] msg2_q, msg2_d;
    logic                ack1_q, ack1_d;
    logic                ack2_q, ack2_d;
    logic [DIGITS_W-1:0] content_q, content_d;
    logic                disp_en_q, disp_en_d;
    logic [1:0]          src_q, src_d;
    logic                busy_q, busy_d;
    logic                bg_blink_q, bg_blink_d;

    logic expired;
    logic take1;
    logic take2;
    logic blink_restart;
    logic blink_enable;
    logic blink_phase;

    // Next-state logic: cancel dominates, then msg2, then msg1, then hold expiry.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        msg1_d  = msg1_q;
        msg2_d  = msg2_q;
        ack1_d  = 1'b0;
        ack2_d  = 1'b0;
        take1   = 1'b0;
        take2   = 1'b0;
        expired = (state_q != ST_BG) && (hold_q == '0);

        if (cancel) begin
            state_d = ST_BG;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_BG: begin
                    take2 = msg2_req;
                    take1 = !msg2_req && msg1_req;
                end
                ST_MSG1: begin
                    if (msg2_req) begin
                        take2 = 1'b1;
                    end else if (expired) begin
                        take1 = msg1_req;
                    end
                end
                ST_MSG2: begin
                    if (expired) begin
                        take2 = msg2_req;
                        take1 = !msg2_req && msg1_req;
                    end
                end
                default: begin
                    take1 = 1'b0;
                    take2 = 1'b0;
                end
            endcase

            if (take2) begin
                state_d = ST_MSG2;
                msg2_d  = msg2_digits;
                hold_d  = HOLD_LOAD;
                ack2_d  = 1'b1;
            end else if (take1) begin
                state_d = ST_MSG1;
                msg1_d  = msg1_digits;
                hold_d  = HOLD_LOAD;
                ack1_d  = 1'b1;
            end else if (expired || (state_q != ST_MSG1 && state_q != ST_MSG2)) begin
                state_d = ST_BG;
            end else begin
                hold_d = hold_q - 1'b1;
            end
        end
    end

    // Blink restarts on bg_blink rising and on the first cycle back in BG (src still shows a message).
    assign blink_restart = (bg_blink && !bg_blink_q) || (state_q == ST_BG && src_q != SRC_BG);
    assign blink_enable  = bg_blink && (state_q == ST_BG);

    blink_gen #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blink_gen (
        .clk_500Hz (clk_500Hz),
        .rst_n     (rst_n),
        .restart   (blink_restart),
        .enable    (blink_enable),
        .phase     (blink_phase)
    );

    always_comb begin
        case (state_q)
            ST_MSG1: content_d = msg1_q;
            ST_MSG2: content_d = msg2_q;
            default: content_d = bg_digits;
        endcase
        disp_en_d = 1'b1;
        if (state_q == ST_BG && bg_blink) begin
            disp_en_d = blink_phase;
        end
        src_d      = state_q;
        busy_d     = (state_q != ST_BG);
        bg_blink_d = bg_blink;
    end

    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BG;
            hold_q     <= '0;
            msg1_q     <= '0;
            msg2_q     <= '0;
            ack1_q     <= 1'b0;
            ack2_q     <= 1'b0;
            content_q  <= '0;
            disp_en_q  <= 1'b0;
            src_q      <= SRC_BG;
            busy_q     <= 1'b0;
            bg_blink_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            msg1_q     <= msg1_d;
            msg2_q     <= msg2_d;
            ack1_q     <= ack1_d;
            ack2_q     <= ack2_d;
            content_q  <= content_d;
            disp_en_q  <= disp_en_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
            bg_blink_q <= bg_blink_d;
        end
    end

    assign msg1_ack   = ack1_q;
    assign msg2_ack   = ack2_q;
    assign disp_en    = disp_en_q;
    assign active_src = src_q;
    assign busy       = busy_q;
    assign content_0  = content_q[3:0];
    assign content_1  = content_q[7:4];
    assign content_2  = content_q[11:8];
    assign content_3  = content_q[15:12];

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_TICKS=8, BLINK_HALF=3.
// Observed vector = {disp_en, busy, active_src, msg1_ack, msg2_ack, content_3..0}.
module tb_display_arbiter;

    logic        clk_500Hz = 1'b0;
    logic        rst_n;
    logic [15:0] bg_digits;
    logic        bg_blink;
    logic        msg1_req;
    logic [15:0] msg1_digits;
    logic        msg1_ack;
    logic        msg2_req;
    logic [15:0] msg2_digits;
    logic        msg2_ack;
    logic        cancel;
    logic        disp_en;
    logic [3:0]  content_0, content_1, content_2, content_3;
    logic [1:0]  active_src;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [21:0] obs;
    assign obs = {disp_en, busy, active_src, msg1_ack, msg2_ack,
                  content_3, content_2, content_1, content_0};

    display_arbiter #(
        .HOLD_TICKS (8),
        .BLINK_HALF (3)
    ) dut (
        .clk_500Hz   (clk_500Hz),
        .rst_n       (rst_n),
        .bg_digits   (bg_digits),
        .bg_blink    (bg_blink),
        .msg1_req    (msg1_req),
        .msg1_digits (msg1_digits),
        .msg1_ack    (msg1_ack),
        .msg2_req    (msg2_req),
        .msg2_digits (msg2_digits),
        .msg2_ack    (msg2_ack),
        .cancel      (cancel),
        .disp_en     (disp_en),
        .content_0   (content_0),
        .content_1   (content_1),
        .content_2   (content_2),
        .content_3   (content_3),
        .active_src  (active_src),
        .busy        (busy)
    );

    always #5 clk_500Hz = ~clk_500Hz;

    task automatic tick();
        @(posedge clk_500Hz);
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] exp;
        rst_n = 1'b0; bg_digits = 16'h1234; bg_blink = 1'b0;
        msg1_req = 1'b0; msg2_req = 1'b0; cancel = 1'b0;
        msg1_digits = 16'h0; msg2_digits = 16'h0;
        tick(); tick();
        exp = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL reset_hold got=%h exp=%h", obs, exp); end
        else $display("reset_hold obs=%h", obs);
        rst_n = 1'b1;
        tick(); tick();
        exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h1234};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, exp); end
        else $display("reset_release obs=%h", obs);
    endtask

    task automatic test_bg_track();
        logic [21:0] exp;
        bg_digits = 16'h5678;
        tick();
        exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h5678};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL bg_track got=%h exp=%h", obs, exp); end
        else $display("bg_track obs=%h", obs);
        bg_digits = 16'h1234;
        tick();
    endtask

    task automatic test_msg1();
        logic [21:0] exp;
        msg1_digits = 16'hAB01; msg1_req = 1'b1;
        tick();
        msg1_req = 1'b0;
        exp = {1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 16'h1234};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL msg1_accept got=%h exp=%h", obs, exp); end
        else $display("msg1_accept obs=%h", obs);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 16'hAB01};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL msg1_hold[%0d] got=%h exp=%h", i, obs, exp); end
            else $display("msg1_hold[%0d] obs=%h", i, obs);
        end
        tick();
        exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h1234};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL msg1_expire got=%h exp=%h", obs, exp); end
        else $display("msg1_expire obs=%h", obs);
    endtask

    task automatic test_preempt();
        logic [21:0] exp;
        msg1_digits = 16'hAB01; msg1_req = 1'b1;
        tick();
        msg1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 16'hAB01};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL pre_msg1[%0d] got=%h exp=%h", i, obs, exp); end
            else $display("pre_msg1[%0d] obs=%h", i, obs);
        end
        msg2_digits = 16'hEEEE; msg2_req = 1'b1;
        tick();
        msg2_req = 1'b0;
        exp = {1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 16'hAB01};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL pre_ack2 got=%h exp=%h", obs, exp); end
        else $display("pre_ack2 obs=%h", obs);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'hEEEE};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL pre_msg2[%0d] got=%h exp=%h", i, obs, exp); end
            else $display("pre_msg2[%0d] obs=%h", i, obs);
        end
        tick();
        exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h1234};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL pre_no_resume got=%h exp=%h", obs, exp); end
        else $display("pre_no_resume obs=%h", obs);
    endtask

    task automatic test_simultaneous();
        logic [21:0] exp;
        logic        a1;
        msg1_digits = 16'hAB01; msg2_digits = 16'hEEEE;
        msg1_req = 1'b1; msg2_req = 1'b1;
        tick();
        msg2_req = 1'b0;
        exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'h1234};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL sim_ack2 got=%h exp=%h", obs, exp); end
        else $display("sim_ack2 obs=%h", obs);
        for (int i = 0; i < 8; i++) begin
            tick();
            a1 = (i == 7) ? 1'b1 : 1'b0;
            exp = {1'b1, 1'b1, 2'd2, a1, 1'b0, 16'hEEEE};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL sim_msg2[%0d] got=%h exp=%h", i, obs, exp); end
            else $display("sim_msg2[%0d] obs=%h", i, obs);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 16'hAB01};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL sim_msg1[%0d] got=%h exp=%h", i, obs, exp); end
            else $display("sim_msg1[%0d] obs=%h", i, obs);
            if (i == 6) msg1_req = 1'b0;
        end
        tick();
        exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h1234};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL sim_done got=%h exp=%h", obs, exp); end
        else $display("sim_done obs=%h", obs);
    endtask

    task automatic test_blink();
        logic [21:0] exp;
        logic [4:0]  pat_a;
        logic [3:0]  pat_b;
        pat_a = 5'b00111;
        pat_b = 4'b0111;
        bg_blink = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = {pat_a[i], 1'b0, 2'd0, 1'b0, 1'b0, 16'h1234};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL blink_rise[%0d] got=%h exp=%h", i, obs, exp); end
            else $display("blink_rise[%0d] obs=%h", i, obs);
        end
        msg1_digits = 16'hAB01; msg1_req = 1'b1;
        tick();
        msg1_req = 1'b0;
        exp = {1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'h1234};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL blink_accept got=%h exp=%h", obs, exp); end
        else $display("blink_accept obs=%h", obs);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 16'hAB01};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL blink_msg[%0d] got=%h exp=%h", i, obs, exp); end
            else $display("blink_msg[%0d] obs=%h", i, obs);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = {pat_b[i], 1'b0, 2'd0, 1'b0, 1'b0, 16'h1234};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL blink_reentry[%0d] got=%h exp=%h", i, obs, exp); end
            else $display("blink_reentry[%0d] obs=%h", i, obs);
        end
        bg_blink = 1'b0;
        tick();
        exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h1234};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL blink_off got=%h exp=%h", obs, exp); end
        else $display("blink_off obs=%h", obs);
    endtask

    task automatic test_cancel();
        logic [21:0] exp;
        msg2_digits = 16'hEEEE; msg2_req = 1'b1;
        tick();
        msg2_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = {1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'hEEEE};
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL cancel_msg2[%0d] got=%h exp=%h", i, obs, exp); end
            else $display("cancel_msg2[%0d] obs=%h", i, obs);
        end
        cancel = 1'b1; msg1_req = 1'b1;
        tick();
        exp = {1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'hEEEE};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL cancel_edge got=%h exp=%h", obs, exp); end
        else $display("cancel_edge obs=%h", obs);
        cancel = 1'b0; msg1_req = 1'b0;
        tick();
        exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h1234};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL cancel_bg got=%h exp=%h", obs, exp); end
        else $display("cancel_bg obs=%h", obs);
    endtask

    task automatic test_reset_mid();
        logic [21:0] exp;
        msg1_digits = 16'hAB01; msg1_req = 1'b1;
        tick();
        msg1_req = 1'b0;
        tick(); tick();
        exp = {1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 16'hAB01};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL rstmid_pre got=%h exp=%h", obs, exp); end
        else $display("rstmid_pre obs=%h", obs);
        rst_n = 1'b0;
        #1;
        exp = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL rstmid_async got=%h exp=%h", obs, exp); end
        else $display("rstmid_async obs=%h", obs);
        tick();
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL rstmid_held got=%h exp=%h", obs, exp); end
        else $display("rstmid_held obs=%h", obs);
        rst_n = 1'b1;
        tick();
        exp = {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h1234};
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL rstmid_release got=%h exp=%h", obs, exp); end
        else $display("rstmid_release obs=%h", obs);
    endtask

    initial begin
        test_reset();
        test_bg_track();
        test_msg1();
        test_preempt();
        test_simultaneous();
        test_blink();
        test_cancel();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
